// File: rtl/i2c_slave_regfile.sv
// Purpose: I2C slave with a byte-wide register file, register pointer with auto-increment/wrap, repeated START.
// Latency: pin-to-event SYNC_STAGES+1 core clocks; local read of reg_data_o is combinational.
// Backpressure: none; the slave never stretches SCL, every accepted byte is handled at bus rate.
//
// Ports:
//   i2c_core_clock_i / i2c_core_reset_n_i : core clock (>= 8x SCL) and async active-low reset
//   scl_i / sda_i                         : raw pin levels, oversampled through synchronisers
//   sda_oe_o                              : 1 pulls SDA low (open drain), 0 releases
//   start_o / stop_o                      : one-cycle pulses on (repeated) START and STOP
//   busy_o                                : set on address match, cleared on START/STOP
//   reg_addr_i / reg_data_o               : local combinational register read
//   wr_valid_o / wr_addr_o / wr_data_o    : one-cycle notification of each committed I2C write
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        PTR_W       = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             i2c_core_clock_i,
    input  logic             i2c_core_reset_n_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe_o,
    output logic             start_o,
    output logic             stop_o,
    output logic             busy_o,
    input  logic [PTR_W-1:0] reg_addr_i,
    output logic [7:0]       reg_data_o,
    output logic             wr_valid_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers plus one history flop for edge detection.
    // Reset to 1 so an idle (pulled-up) bus produces no edges.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    always_ff @(posedge i2c_core_clock_i or negedge i2c_core_reset_n_i) begin
        if (!i2c_core_reset_n_i) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise =  w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl &  r_scl_d;
    // SCL must be high both before and after the SDA edge to count as a bus condition.
    assign w_start    = w_scl & r_scl_d &  r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d &  w_sda;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_sda_oe;
    logic             r_busy;
    logic [PTR_W-1:0] r_ptr;
    logic             r_rw;
    logic             r_start;
    logic             r_stop;
    logic             r_wr_vld;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_wr_dat;
    logic [7:0]       r_regs [NUM_REGS];

    state_t           w_state_nxt;
    logic [3:0]       w_cnt_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_sda_oe_nxt;
    logic             w_busy_nxt;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_rw_nxt;
    logic             w_start_nxt;
    logic             w_stop_nxt;
    logic             w_wr_vld_nxt;
    logic [PTR_W-1:0] w_wr_addr_nxt;
    logic [7:0]       w_wr_dat_nxt;
    logic             w_reg_we;
    logic [PTR_W-1:0] w_ptr_inc;
    logic             w_ptr_in_range;

    assign w_ptr_inc      = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_in_range = ({1'b0, r_shift} < 9'(NUM_REGS));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_ptr_nxt     = r_ptr;
        w_rw_nxt      = r_rw;
        w_start_nxt   = 1'b0;
        w_stop_nxt    = 1'b0;
        w_wr_vld_nxt  = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_dat_nxt  = r_wr_dat;
        w_reg_we      = 1'b0;

        if (w_start) begin
            w_state_nxt  = ADDR;
            w_cnt_nxt    = '0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_start_nxt  = 1'b1;
        end else if (w_stop) begin
            w_state_nxt  = IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_stop_nxt   = 1'b1;
        end else begin
            case (r_state)
                ADDR, PTR, WDATA: begin
                    if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
                        w_shift_nxt = {r_shift[6:0], w_sda};
                        w_cnt_nxt   = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        if (r_state == ADDR) begin
                            if (r_shift[7:1] == SLAVE_ADDR) begin
                                w_sda_oe_nxt = 1'b1;
                                w_busy_nxt   = 1'b1;
                                w_rw_nxt     = r_shift[0];
                                w_state_nxt  = ADDR_ACK;
                                // Preload the first read byte so the ACK-slot fall can present it.
                                if (r_shift[0]) begin
                                    w_shift_nxt = r_regs[r_ptr];
                                end
                            end else begin
                                w_sda_oe_nxt = 1'b0;
                                w_state_nxt  = IGNORE;
                            end
                        end else if (r_state == PTR) begin
                            if (w_ptr_in_range) begin
                                w_sda_oe_nxt = 1'b1;
                                w_ptr_nxt    = r_shift[PTR_W-1:0];
                                w_state_nxt  = PTR_ACK;
                            end else begin
                                w_sda_oe_nxt = 1'b0;
                                w_state_nxt  = IGNORE;
                            end
                        end else begin
                            // Commit the data byte at the moment the ACK is driven.
                            w_reg_we      = 1'b1;
                            w_wr_vld_nxt  = 1'b1;
                            w_wr_addr_nxt = r_ptr;
                            w_wr_dat_nxt  = r_shift;
                            w_sda_oe_nxt  = 1'b1;
                            w_ptr_nxt     = w_ptr_inc;
                            w_state_nxt   = WDATA_ACK;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_nxt = '0;
                        if (r_rw) begin
                            // End of the ACK slot doubles as the first data bit drive.
                            w_sda_oe_nxt = ~r_shift[7];
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_state_nxt  = RDATA;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = PTR;
                        end
                    end
                end

                PTR_ACK, WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = WDATA;
                    end
                end

                RDATA: begin
                    // r_bit_cnt counts master sample edges; each fall presents the next bit
                    // until all eight have been sampled, then SDA is handed to the master.
                    if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
                        w_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = RACK;
                        end else begin
                            w_sda_oe_nxt = ~r_shift[7];
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                        end
                    end
                end

                RACK: begin
                    if (w_scl_rise) begin
                        if (!w_sda) begin
                            w_ptr_nxt   = w_ptr_inc;
                            w_shift_nxt = r_regs[w_ptr_inc];
                            w_cnt_nxt   = '0;
                            w_state_nxt = RDATA;
                        end else begin
                            w_state_nxt = IGNORE;
                        end
                    end
                end

                default: begin
                    // IDLE and IGNORE only react to START/STOP.
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge i2c_core_clock_i or negedge i2c_core_reset_n_i) begin
        if (!i2c_core_reset_n_i) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_ptr     <= '0;
            r_rw      <= 1'b0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_dat  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_ptr     <= w_ptr_nxt;
            r_rw      <= w_rw_nxt;
            r_start   <= w_start_nxt;
            r_stop    <= w_stop_nxt;
            r_wr_vld  <= w_wr_vld_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_dat  <= w_wr_dat_nxt;
        end
    end

    // Register file: a local read in the same cycle as a write sees the old value.
    always_ff @(posedge i2c_core_clock_i or negedge i2c_core_reset_n_i) begin
        if (!i2c_core_reset_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_reg_we) begin
            r_regs[r_ptr] <= r_shift;
        end
    end

    assign reg_data_o = r_regs[reg_addr_i];
    assign sda_oe_o   = r_sda_oe;
    assign start_o    = r_start;
    assign stop_o     = r_stop;
    assign busy_o     = r_busy;
    assign wr_valid_o = r_wr_vld;
    assign wr_addr_o  = r_wr_addr;
    assign wr_data_o  = r_wr_dat;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bus master tasks drive SCL/SDA (open drain with the DUT),
// a register-array model predicts ACKs, read data, write notifications and pointer motion.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

    localparam int NUM_REGS = 16;
    localparam int PTR_W    = 4;
    localparam int Q        = 5;   // core clocks per quarter SCL period

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             scl_m = 1'b1;
    logic             sda_m = 1'b1;
    logic             sda_oe;
    logic             sda_line;
    logic             start_p;
    logic             stop_p;
    logic             busy;
    logic [PTR_W-1:0] reg_addr = '0;
    logic [7:0]       reg_data;
    logic             wr_vld;
    logic [PTR_W-1:0] wr_addr;
    logic [7:0]       wr_dat;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_regfile #(
        .SLAVE_ADDR (7'h50),
        .NUM_REGS   (NUM_REGS),
        .SYNC_STAGES(2)
    ) dut (
        .i2c_core_clock_i  (clk),
        .i2c_core_reset_n_i(rst_n),
        .scl_i             (scl_m),
        .sda_i             (sda_line),
        .sda_oe_o          (sda_oe),
        .start_o           (start_p),
        .stop_o            (stop_p),
        .busy_o            (busy),
        .reg_addr_i        (reg_addr),
        .reg_data_o        (reg_data),
        .wr_valid_o        (wr_vld),
        .wr_addr_o         (wr_addr),
        .wr_data_o         (wr_dat)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitors
    int          n_start = 0;
    int          n_stop  = 0;
    bit          oe_seen = 0;
    bit          busy_seen = 0;
    logic [11:0] wr_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (start_p) n_start++;
            if (stop_p)  n_stop++;
            if (sda_oe)  oe_seen = 1;
            if (busy)    busy_seen = 1;
            if (wr_vld)  wr_q.push_back({wr_addr, wr_dat});
        end
    end

    // Reference model
    logic [7:0]  m_regs [NUM_REGS];
    int          m_ptr = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  wbuf [8];

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_m = b;    qwait();
        scl_m = 1'b1; qwait();
        s = sda_line; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] b);
        logic s;
        logic nack_lvl;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            b[i] = s;
        end
        nack_lvl = ~master_ack;
        bus_bit(nack_lvl, s);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_addr = 4'(i);
            #1;
            check(tag, 32'(reg_data), 32'(m_regs[i]));
        end
    endtask

    // START, address+W, pointer, n data bytes from wbuf, STOP
    task automatic xfer_write(input logic [6:0] a, input logic [7:0] p, input int n);
        logic ack;
        bit   match;
        bit   ok;
        int   s0;
        int   p0;
        s0 = n_start; p0 = n_stop;
        wr_q.delete(); exp_q.delete();
        oe_seen = 0; busy_seen = 0;
        bus_start();
        match = (a == 7'h50);
        send_byte({a, 1'b0}, ack);
        check("addr_ack", 32'(ack), 32'(match));
        check("busy_after_addr", 32'(busy), 32'(match));
        send_byte(p, ack);
        ok = match && (int'(p) < NUM_REGS);
        check("ptr_ack", 32'(ack), 32'(ok));
        if (ok) m_ptr = int'(p);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack);
            check("data_ack", 32'(ack), 32'(ok));
            if (ok) begin
                m_regs[m_ptr] = wbuf[i];
                exp_q.push_back({4'(m_ptr), wbuf[i]});
                m_ptr = (m_ptr + 1) % NUM_REGS;
            end
        end
        bus_stop();
        qwait();
        check("busy_after_stop", 32'(busy), 32'd0);
        check("wr_count", 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check("wr_event", 32'(wr_q[i]), 32'(exp_q[i]));
        check("start_pulses", 32'(n_start - s0), 32'd1);
        check("stop_pulses", 32'(n_stop - p0), 32'd1);
        if (!match) begin
            check("oe_never_on_mismatch", 32'(oe_seen), 32'd0);
            check("busy_never_on_mismatch", 32'(busy_seen), 32'd0);
        end
    endtask

    // Optional pointer set + repeated START, then address+R and n reads (ACK all but the last)
    task automatic xfer_read(input logic [6:0] a, input bit set_ptr, input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] b;
        logic [7:0] expb;
        bit         match;
        int         s0;
        int         nst;
        s0 = n_start;
        bus_start();
        nst = 1;
        if (set_ptr) begin
            send_byte({7'h50, 1'b0}, ack);
            check("rd_setup_addr_ack", 32'(ack), 32'd1);
            send_byte(p, ack);
            check("rd_setup_ptr_ack", 32'(ack), 32'(int'(p) < NUM_REGS));
            if (int'(p) < NUM_REGS) m_ptr = int'(p);
            bus_start();
            nst = 2;
        end
        match = (a == 7'h50);
        send_byte({a, 1'b1}, ack);
        check("raddr_ack", 32'(ack), 32'(match));
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, b);
            expb = match ? m_regs[m_ptr] : 8'hFF;
            check("rdata", 32'(b), 32'(expb));
            if (match && (i < n - 1)) m_ptr = (m_ptr + 1) % NUM_REGS;
        end
        check("oe_released_after_nack", 32'(sda_oe), 32'd0);
        bus_stop();
        qwait();
        check("rd_start_pulses", 32'(n_start - s0), 32'(nst));
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] exp_b;
        logic       exp_oe;
        int         kind;
        int         n;
        logic [6:0] a;
        logic [7:0] p;

        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_start", 32'(start_p), 32'd0);
        check("rst_stop", 32'(stop_p), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_valid", 32'(wr_vld), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_dat), 32'd0);
        check("rst_reg0", 32'(reg_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Plain write of two bytes at pointer 3
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        xfer_write(7'h50, 8'h03, 2);
        check_regs("regs_after_write");

        // Pointer set, repeated START, two reads
        xfer_read(7'h50, 1'b1, 8'h03, 2);

        // Wrap from the last register to register 0
        wbuf[0] = 8'h5A; wbuf[1] = 8'h6B;
        xfer_write(7'h50, 8'h0F, 2);
        check_regs("regs_after_wrap");

        // Wrong device address
        wbuf[0] = 8'hC3;
        xfer_write(7'h51, 8'h01, 1);

        // Out-of-range pointer, then read from the retained pointer
        wbuf[0] = 8'h99; wbuf[1] = 8'h77;
        xfer_write(7'h50, 8'h20, 2);
        xfer_read(7'h50, 1'b0, 8'h00, 1);
        check_regs("regs_after_bad_ptr");

        // Randomised mix of transactions
        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 4);
            case (kind)
                0: begin
                    a = ($urandom_range(0, 5) == 0) ? 7'h51 : 7'h50;
                    p = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
                    for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
                    xfer_write(a, p, n);
                end
                1: xfer_read(7'h50, 1'b0, 8'h00, n);
                2: xfer_read(7'h50, 1'b1, 8'($urandom_range(0, 15)), n);
                default: xfer_read(7'h52, 1'b0, 8'h00, 1);
            endcase
        end
        check_regs("regs_after_random");

        // Reset in the middle of the 4th bit of a read byte
        wbuf[0] = 8'hE7;
        xfer_write(7'h50, 8'h05, 1);
        xfer_write(7'h50, 8'h05, 0);
        bus_start();
        send_byte({7'h50, 1'b1}, ack);
        check("mid_rd_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1;
        repeat (2) @(negedge clk);
        exp_b  = m_regs[5];
        exp_oe = ~exp_b[4];
        check("oe_before_reset", 32'(sda_oe), 32'(exp_oe));
        rst_n = 1'b0;
        #1;
        check("oe_at_reset", 32'(sda_oe), 32'd0);
        check("busy_at_reset", 32'(busy), 32'd0);
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        check_regs("regs_after_reset");
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Normal operation after reset
        wbuf[0] = 8'($urandom_range(0, 255)); wbuf[1] = 8'($urandom_range(0, 255));
        xfer_write(7'h50, 8'h09, 2);
        xfer_read(7'h50, 1'b1, 8'h09, 2);
        check_regs("regs_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
